// File: rtl/y_frame_gen.sv
// ---------------------------------------------------------------------------
// y_frame_gen
// Synthetic Y-channel video source. Generates per_frame_vsync /
// per_frame_href / per_frame_clken / per_img_Y timing for a frame of
// (V_SYNC + V_BACK + IMG_VDISP) lines of (IMG_HDISP + H_BLANK) pixel ticks,
// filled with one of four test patterns chosen at frame start.
//
// Ports:
//   clk              pixel/system clock, all logic on the rising edge
//   rst              synchronous active-high reset
//   enable           level; requests frames (sampled in IDLE and at frame end)
//   pattern_sel[1:0] 0 h-ramp, 1 v-ramp, 2 8x8 checkerboard, 3 diagonal ramp
//   per_frame_vsync  high during the first V_SYNC lines of a frame
//   per_frame_href   high on active pixels only
//   per_frame_clken  one-clock strobe per pixel tick
//   per_img_Y[7:0]   pixel brightness, 0 whenever href is low
//   frame_done       one-clock pulse with the clken of the last frame tick
// ---------------------------------------------------------------------------
module y_frame_gen #(
    parameter logic [9:0] IMG_HDISP = 10'd640,
    parameter logic [9:0] IMG_VDISP = 10'd480,
    parameter logic [9:0] H_BLANK   = 10'd160,
    parameter logic [9:0] V_SYNC    = 10'd2,
    parameter logic [9:0] V_BACK    = 10'd2,
    parameter logic [3:0] CLKEN_DIV = 4'd1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       enable,
    input  logic [1:0] pattern_sel,
    output logic       per_frame_vsync,
    output logic       per_frame_href,
    output logic       per_frame_clken,
    output logic [7:0] per_img_Y,
    output logic       frame_done
);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    // Line counter is 12 bits wide so that V_SYNC+V_BACK+IMG_VDISP can never
    // overflow it, whatever the 10-bit parameters are set to.
    localparam logic [9:0]  LINE_LAST    = IMG_HDISP + H_BLANK - 10'd1;
    localparam logic [11:0] VSYNC_END    = {2'b00, V_SYNC};
    localparam logic [11:0] ACTIVE_START = {2'b00, V_SYNC} + {2'b00, V_BACK};
    localparam logic [11:0] FRAME_LAST   = ACTIVE_START + {2'b00, IMG_VDISP} - 12'd1;
    localparam logic [3:0]  DIV_LAST     = CLKEN_DIV - 4'd1;

    // Test pattern value for an active pixel; only the low 8 bits of x and y
    // matter because every pattern is truncated to 8 bits.
    function automatic logic [7:0] pattern_pix(
        input logic [1:0] sel,
        input logic [7:0] x,
        input logic [7:0] y
    );
        logic [7:0] pix;
        case (sel)
            2'd0:    pix = x;
            2'd1:    pix = y;
            2'd2:    pix = (x[3] ^ y[3]) ? 8'hFF : 8'h00;
            2'd3:    pix = x + y;
            default: pix = 8'h00;
        endcase
        return pix;
    endfunction

    logic [0:0]  state_r;
    logic [3:0]  div_r;
    logic [9:0]  col_r;
    logic [11:0] line_r;
    logic [1:0]  pat_r;

    logic        vsync_r;
    logic        href_r;
    logic        clken_r;
    logic [7:0]  y_r;
    logic        done_r;

    logic        tick_s;
    logic        last_col_s;
    logic        last_line_s;
    logic        frame_end_s;
    logic        vsync_s;
    logic        href_s;
    logic [7:0]  y_row_s;
    logic [7:0]  pix_s;
    logic [9:0]  col_nxt_s;
    logic [11:0] line_nxt_s;

    // Tick detection and the output values for the current position (l, c).
    always_comb begin
        tick_s      = (state_r == ST_RUN) && (div_r == DIV_LAST);
        last_col_s  = (col_r == LINE_LAST);
        last_line_s = (line_r == FRAME_LAST);
        frame_end_s = tick_s && last_col_s && last_line_s;
        vsync_s     = (line_r < VSYNC_END);
        href_s      = (line_r >= ACTIVE_START) && (col_r < IMG_HDISP);
        // Only the low byte of y is consumed, so subtract modulo 256.
        y_row_s     = line_r[7:0] - ACTIVE_START[7:0];
        if (href_s) begin
            pix_s = pattern_pix(pat_r, col_r[7:0], y_row_s);
        end else begin
            pix_s = 8'h00;
        end
    end

    // Next raster position: column wraps at the end of a line, line wraps at
    // the end of the frame so back-to-back frames need no extra cycle.
    always_comb begin
        col_nxt_s  = col_r + 10'd1;
        line_nxt_s = line_r;
        if (last_col_s) begin
            col_nxt_s = 10'd0;
            if (last_line_s) begin
                line_nxt_s = 12'd0;
            end else begin
                line_nxt_s = line_r + 12'd1;
            end
        end else begin
            col_nxt_s  = col_r + 10'd1;
            line_nxt_s = line_r;
        end
    end

    // Frame state machine, pixel divider, raster counters and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
            div_r   <= 4'd0;
            col_r   <= 10'd0;
            line_r  <= 12'd0;
            pat_r   <= 2'd0;
            vsync_r <= 1'b0;
            href_r  <= 1'b0;
            clken_r <= 1'b0;
            y_r     <= 8'h00;
            done_r  <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    div_r   <= 4'd0;
                    col_r   <= 10'd0;
                    line_r  <= 12'd0;
                    pat_r   <= pattern_sel;
                    vsync_r <= 1'b0;
                    href_r  <= 1'b0;
                    clken_r <= 1'b0;
                    y_r     <= 8'h00;
                    done_r  <= 1'b0;
                    if (enable) begin
                        state_r <= ST_RUN;
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_RUN: begin
                    if (tick_s) begin
                        // Outputs describe the position held before this edge.
                        div_r   <= 4'd0;
                        clken_r <= 1'b1;
                        vsync_r <= vsync_s;
                        href_r  <= href_s;
                        y_r     <= pix_s;
                        done_r  <= frame_end_s;
                        col_r   <= col_nxt_s;
                        line_r  <= line_nxt_s;
                        if (frame_end_s) begin
                            // Frame boundary is the only place a new pattern
                            // or a stop request takes effect.
                            if (enable) begin
                                pat_r   <= pattern_sel;
                                state_r <= ST_RUN;
                            end else begin
                                pat_r   <= pat_r;
                                state_r <= ST_IDLE;
                            end
                        end else begin
                            pat_r   <= pat_r;
                            state_r <= ST_RUN;
                        end
                    end else begin
                        // Between ticks vsync/href/Y hold their values.
                        div_r   <= div_r + 4'd1;
                        clken_r <= 1'b0;
                        done_r  <= 1'b0;
                        state_r <= ST_RUN;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                    div_r   <= 4'd0;
                    col_r   <= 10'd0;
                    line_r  <= 12'd0;
                    pat_r   <= 2'd0;
                    vsync_r <= 1'b0;
                    href_r  <= 1'b0;
                    clken_r <= 1'b0;
                    y_r     <= 8'h00;
                    done_r  <= 1'b0;
                end
            endcase
        end
    end

    assign per_frame_vsync = vsync_r;
    assign per_frame_href  = href_r;
    assign per_frame_clken = clken_r;
    assign per_img_Y       = y_r;
    assign frame_done      = done_r;

endmodule
